sd_drive_arbiter: RTL and testbench
===================================

// Module: sd_drive_arbiter
// PURPOSE
//   Shares one hps_io SD block channel between NUM_DRIVES virtual disk drives. Typical clients are the WD1793 floppy drives 0..3 and future HDD images.
//   - Arbitrates drive read/write requests with round-robin fairness.
//   - Latches the winner's LBA and block count.
//   - Forwards the ack and buffer-write strobe to the owning drive only.
//   - Muxes the owner's buffer data back to the host.
//   Sits between the drive controllers in coco3fpga and hps_io.
// PARAMETERS
//   NUM_DRIVES   4        number of drive clients, 2..8
//   LBA_W        32       LBA width
//   CNT_W        6        block-count width (blocks-1)
//   TIMEOUT_CYC  2**22    watchdog limit in clk_sys cycles (only with SD_ARB_TIMEOUT_EN)
// PORTS
//   clk_sys       in   1                  system clock, all logic posedge
//   reset         in   1                  synchronous, active-high
//   drv_rd        in   NUM_DRIVES         per-drive read request; drive holds it until its ack rises
//   drv_wr        in   NUM_DRIVES         per-drive write request; same rule
//   drv_lba       in   NUM_DRIVES*LBA_W   flat; drive i at [i*LBA_W +: LBA_W]
//   drv_blk_cnt   in   NUM_DRIVES*CNT_W   flat, same packing
//   drv_buff_din  in   NUM_DRIVES*8       per-drive write data for the host
//   drv_ack       out  NUM_DRIVES         one-hot ack to the owner
//   drv_buff_wr   out  NUM_DRIVES         sd_buff_wr gated to the owner
//   host_rd       out  1                  single-channel request to hps_io
//   host_wr       out  1                  single-channel request to hps_io
//   host_lba      out  LBA_W              latched LBA of the owner
//   host_blk_cnt  out  CNT_W              latched block count of the owner
//   host_drive    out  $clog2(NUM_DRIVES) owner index; selects the hps_io drive slot
//   host_ack      in   1                  ack from hps_io
//   host_buff_wr  in   1                  buffer write strobe from hps_io
//   host_buff_din out  8                  = drv_buff_din of the owner (combinational mux)
//   busy          out  1                  high in every state except IDLE
//   err           out  1                  1-cycle pulse on a watchdog abort (tied 0 without the macro)
// BEHAVIOUR
//   Reset
//   - All outputs 0. State IDLE. Round-robin pointer ptr=0.
//   - reset mid-transfer aborts the transfer immediately; no ack is sent to the owner.
//   FSM IDLE -> REQ -> XFER -> DONE -> IDLE
//   - IDLE: pend_i = drv_rd[i] | drv_wr[i]. Winner = first pending index scanning ptr, ptr+1, ..., wrapping mod NUM_DRIVES.
//     On the next edge latch owner, lba, blk_cnt and dir, then enter REQ. No pending request: stay in IDLE.
//   - dir: rd wins when a drive asserts rd and wr together.
//   - REQ: host_rd = dir_rd, host_wr = ~dir_rd, both registered. On host_ack==1: enter XFER, drop host_rd/wr the same cycle.
//   - XFER: drv_ack[owner] = 1 (registered, 1 cycle after host_ack).
//     drv_buff_wr[owner] = host_buff_wr (combinational). Other drives see 0.
//     On host_ack==0: enter DONE.
//   - DONE: drv_ack = 0. ptr <= owner+1; NUM_DRIVES-1 wraps to 0. Enter IDLE.
//   Arbitration timing
//   - Minimum request-to-request turnaround is 1 idle cycle.
//   - A drive's request sampled in DONE is ignored until IDLE.
//   - Requests that change while another drive owns the channel do not disturb host_lba or host_blk_cnt.
//   - host_lba and host_blk_cnt are stable from REQ entry to DONE exit.
//   - host_buff_din follows the owner combinationally. It is valid 0-latency for the hps_io 2-port RAM timing.
// CONFIGURATION
//   SD_ARB_TIMEOUT_EN defined:
//   - A counter clears on REQ entry and counts in REQ and XFER.
//   - When it reaches TIMEOUT_CYC-1: drop host_rd/wr, pulse err for 1 cycle, enter DONE.
//   - The owner never receives an ack; ptr still advances.
//   SD_ARB_TIMEOUT_EN undefined:
//   - No counter; FSM waits indefinitely; err is tied 0.
// STRUCTURE
//   Package sd_arb_pkg:
//   - state enum (IDLE, REQ, XFER, DONE).
//   - function idx_w(n) = $clog2(n).
//   - localparam for the default TIMEOUT_CYC.
//   Sub-module rr_pick #(N):
//   - Combinational round-robin priority encoder.
//   - Inputs: pend[N], ptr. Outputs: grant_idx, any.
// TESTING
//   1 Single read: drv_rd[2]=1, lba=0x123 -> host_rd=1 two cycles later.
//     host_drive=2, host_lba=0x123, drv_ack[2] follows host_ack by 1 cycle. busy=0 after DONE.
//   2 Fairness: drives 0,1,3 hold requests continuously, auto-ack by the host model -> service order 0,1,3,0,1,3. No drive starves.
//   3 rd+wr together on drive 1 -> host_rd=1, host_wr=0. A wr-only request on drive 1 afterwards -> host_wr=1.
//   4 Buffer routing: owner=3, 256 host_buff_wr strobes -> only drv_buff_wr[3] toggles.
//     host_buff_din tracks drv_buff_din[3] byte for byte.
//   5 Reset asserted in XFER -> the next cycle has all outputs 0, ptr=0, no drv_ack pulse.
//   6 (SD_ARB_TIMEOUT_EN, TIMEOUT_CYC=64) host never acks -> host_rd drops at cycle 64 of REQ.
//     err pulses once, then the next pending drive is served.

Source files
------------

// File: rtl/sd_arb_pkg.sv
`default_nettype none
// ============================================================================
// sd_arb_pkg : FSM state type, index-width helper and default watchdog limit
//              shared by the SD drive arbiter files.
// Revision   : 1.0
// ============================================================================
package sd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int c_TIMEOUT_CYC = 2**22;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_drive_arbiter_if.sv
`default_nettype none
// ============================================================================
// sd_drive_arbiter_if : drive-side and hps_io-side signals of the SD arbiter.
//                       slave = arbiter, master = drives + host environment.
// Revision            : 1.0
// ============================================================================
interface sd_drive_arbiter_if #(
  parameter int NUM_DRIVES = 4,
  parameter int LBA_W      = 32,
  parameter int CNT_W      = 6
);
  import sd_arb_pkg::*;

  localparam int c_IW = idx_w(NUM_DRIVES);

  logic [NUM_DRIVES-1:0]       drv_rd;
  logic [NUM_DRIVES-1:0]       drv_wr;
  logic [NUM_DRIVES*LBA_W-1:0] drv_lba;
  logic [NUM_DRIVES*CNT_W-1:0] drv_blk_cnt;
  logic [NUM_DRIVES*8-1:0]     drv_buff_din;
  logic [NUM_DRIVES-1:0]       drv_ack;
  logic [NUM_DRIVES-1:0]       drv_buff_wr;
  logic                        host_rd;
  logic                        host_wr;
  logic [LBA_W-1:0]            host_lba;
  logic [CNT_W-1:0]            host_blk_cnt;
  logic [c_IW-1:0]             host_drive;
  logic                        host_ack;
  logic                        host_buff_wr;
  logic [7:0]                  host_buff_din;
  logic                        busy;
  logic                        err;

  modport slave (
    input  drv_rd, drv_wr, drv_lba, drv_blk_cnt, drv_buff_din, host_ack, host_buff_wr,
    output drv_ack, drv_buff_wr, host_rd, host_wr, host_lba, host_blk_cnt, host_drive,
           host_buff_din, busy, err
  );

  modport master (
    output drv_rd, drv_wr, drv_lba, drv_blk_cnt, drv_buff_din, host_ack, host_buff_wr,
    input  drv_ack, drv_buff_wr, host_rd, host_wr, host_lba, host_blk_cnt, host_drive,
           host_buff_din, busy, err
  );

endinterface
`default_nettype wire

// File: rtl/sd_drive_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// rr_pick  : combinational round-robin priority encoder; the first pending
//            index at or after ptr (wrapping modulo N) wins.
// Revision : 1.0
// ============================================================================
module rr_pick
  import sd_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]        pend,
  input  logic [idx_w(N)-1:0] ptr,
  output logic [idx_w(N)-1:0] grant_idx,
  output logic                any
);

  localparam int c_IW = idx_w(N);

  logic [c_IW-1:0] w_idx [N];

  for (genvar k = 0; k < N; k++) begin : g_rot
    assign w_idx[k] = ((int'(ptr) + k) >= N) ? c_IW'(int'(ptr) + k - N)
                                             : c_IW'(int'(ptr) + k);
  end

  // Descending scan so the smallest offset from ptr is the last to overwrite.
  always_comb begin
    grant_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (pend[w_idx[k]]) grant_idx = w_idx[k];
    end
  end

  assign any = |pend;

endmodule
`default_nettype wire

// File: rtl/sd_drive_arbiter.sv
`default_nettype none
// ============================================================================
// sd_drive_arbiter : shares one hps_io SD block channel between NUM_DRIVES
//                    virtual drives. Optional watchdog: SD_ARB_TIMEOUT_EN.
// Revision         : 1.0
// ============================================================================
module sd_drive_arbiter
  import sd_arb_pkg::*;
#(
  parameter int NUM_DRIVES  = 4,
  parameter int LBA_W       = 32,
  parameter int CNT_W       = 6
`ifdef SD_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = c_TIMEOUT_CYC
`endif
) (
  input  logic              clk_sys,
  input  logic              reset,
  sd_drive_arbiter_if.slave bus
);

  localparam int c_IW = idx_w(NUM_DRIVES);

  state_t                r_state, w_state_nxt;
  logic [c_IW-1:0]       r_ptr, w_ptr_nxt;
  logic [c_IW-1:0]       r_owner, w_owner_nxt;
  logic [LBA_W-1:0]      r_lba, w_lba_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic                  r_dir_rd, w_dir_rd_nxt;
  logic                  r_host_rd, w_host_rd_nxt;
  logic                  r_host_wr, w_host_wr_nxt;
  logic [NUM_DRIVES-1:0] r_drv_ack, w_drv_ack_nxt;
  logic                  r_err, w_err_nxt;

  logic [NUM_DRIVES-1:0] w_pend;
  logic [c_IW-1:0]       w_grant;
  logic                  w_any;
  logic                  w_tmo;

  assign w_pend = bus.drv_rd | bus.drv_wr;

  rr_pick #(
    .N (NUM_DRIVES)
  ) u_rr_pick (
    .pend      (w_pend),
    .ptr       (r_ptr),
    .grant_idx (w_grant),
    .any       (w_any)
  );

`ifdef SD_ARB_TIMEOUT_EN
  localparam int c_TMO_W = $clog2(TIMEOUT_CYC);

  logic [c_TMO_W-1:0] r_tmo_cnt;

  // Held at zero in IDLE so it restarts on every REQ entry.
  always_ff @(posedge clk_sys) begin
    if (reset || r_state == IDLE || r_state == DONE) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
    end
  end

  assign w_tmo = (r_state == REQ || r_state == XFER) &&
                 (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYC - 1));
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_lba     <= '0;
      r_cnt     <= '0;
      r_dir_rd  <= 1'b0;
      r_host_rd <= 1'b0;
      r_host_wr <= 1'b0;
      r_drv_ack <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_owner   <= w_owner_nxt;
      r_lba     <= w_lba_nxt;
      r_cnt     <= w_cnt_nxt;
      r_dir_rd  <= w_dir_rd_nxt;
      r_host_rd <= w_host_rd_nxt;
      r_host_wr <= w_host_wr_nxt;
      r_drv_ack <= w_drv_ack_nxt;
      r_err     <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_owner_nxt   = r_owner;
    w_lba_nxt     = r_lba;
    w_cnt_nxt     = r_cnt;
    w_dir_rd_nxt  = r_dir_rd;
    w_host_rd_nxt = 1'b0;
    w_host_wr_nxt = 1'b0;
    w_drv_ack_nxt = '0;
    w_err_nxt     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_owner_nxt  = w_grant;
          w_lba_nxt    = bus.drv_lba[int'(w_grant)*LBA_W +: LBA_W];
          w_cnt_nxt    = bus.drv_blk_cnt[int'(w_grant)*CNT_W +: CNT_W];
          w_dir_rd_nxt = bus.drv_rd[w_grant];
          w_state_nxt  = REQ;
        end
      end
      REQ: begin
        if (w_tmo) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = DONE;
        end else if (bus.host_ack) begin
          w_drv_ack_nxt[r_owner] = 1'b1;
          w_state_nxt            = XFER;
        end else begin
          w_host_rd_nxt = r_dir_rd;
          w_host_wr_nxt = ~r_dir_rd;
        end
      end
      XFER: begin
        if (w_tmo) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = DONE;
        end else if (bus.host_ack) begin
          w_drv_ack_nxt[r_owner] = 1'b1;
        end else begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_ptr_nxt   = (r_owner == c_IW'(NUM_DRIVES - 1)) ? '0 : r_owner + c_IW'(1);
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Strobe gating stays combinational so hps_io RAM writes land in the same cycle.
  always_comb begin
    bus.drv_buff_wr = '0;
    if (r_state == XFER) bus.drv_buff_wr[r_owner] = bus.host_buff_wr;
  end

  assign bus.busy          = (r_state != IDLE);
  assign bus.host_buff_din = bus.busy ? bus.drv_buff_din[int'(r_owner)*8 +: 8] : 8'h00;
  assign bus.host_rd       = r_host_rd;
  assign bus.host_wr       = r_host_wr;
  assign bus.host_lba      = r_lba;
  assign bus.host_blk_cnt  = r_cnt;
  assign bus.host_drive    = r_owner;
  assign bus.drv_ack       = r_drv_ack;
  assign bus.err           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sd_drive_arbiter.sv
`default_nettype none
// ============================================================================
// tb_sd_drive_arbiter : scoreboard bench for sd_drive_arbiter; expected grants
//                       are queued at request time and checked when served.
// Revision            : 1.0
// ============================================================================
module tb_sd_drive_arbiter;

  localparam int c_N     = 4;
  localparam int c_LBA_W = 32;
  localparam int c_CNT_W = 6;

  typedef struct {
    int          drv;
    logic [31:0] lba;
    logic [5:0]  cnt;
    bit          rd;
  } exp_t;

  logic   clk_sys = 1'b0;
  logic   reset;
  int     checks   = 0;
  int     failures = 0;
  exp_t   sb[$];

  always #5 clk_sys = ~clk_sys;

  sd_drive_arbiter_if #(.NUM_DRIVES(c_N), .LBA_W(c_LBA_W), .CNT_W(c_CNT_W)) bus ();

  sd_drive_arbiter #(
    .NUM_DRIVES (c_N),
    .LBA_W      (c_LBA_W),
    .CNT_W      (c_CNT_W)
`ifdef SD_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(64)
`endif
  ) u_dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic sb_push(input int d, input logic [31:0] lba, input logic [5:0] cnt, input bit rd);
    exp_t e;
    e.drv = d; e.lba = lba; e.cnt = cnt; e.rd = rd;
    sb.push_back(e);
  endtask

  task automatic req(input int d, input bit rd, input bit wr,
                     input logic [31:0] lba, input logic [5:0] cnt);
    bus.drv_lba[d*c_LBA_W +: c_LBA_W]     = lba;
    bus.drv_blk_cnt[d*c_CNT_W +: c_CNT_W] = cnt;
    bus.drv_rd[d] = rd;
    bus.drv_wr[d] = wr;
    sb_push(d, lba, cnt, rd);
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (!(bus.host_rd || bus.host_wr) && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) check_val("req_wait", bus.host_rd | bus.host_wr, 1);
  endtask

  task automatic pop_check(output exp_t e);
    check_val("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
    end else begin
      e.drv = 0; e.lba = '0; e.cnt = '0; e.rd = 1'b0;
    end
    check_val("host_drive", bus.host_drive, e.drv);
    check_val("host_lba", bus.host_lba, e.lba);
    check_val("host_blk_cnt", bus.host_blk_cnt, e.cnt);
    check_val("host_rd", bus.host_rd, e.rd);
    check_val("host_wr", bus.host_wr, !e.rd);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_busy"}, bus.busy, 0);
    check_val({tag, "_host_rd"}, bus.host_rd, 0);
    check_val({tag, "_host_wr"}, bus.host_wr, 0);
    check_val({tag, "_host_lba"}, bus.host_lba, 0);
    check_val({tag, "_host_cnt"}, bus.host_blk_cnt, 0);
    check_val({tag, "_host_drive"}, bus.host_drive, 0);
    check_val({tag, "_drv_ack"}, bus.drv_ack, 0);
    check_val({tag, "_buff_din"}, bus.host_buff_din, 0);
    check_val({tag, "_err"}, bus.err, 0);
  endtask

  // Host model: acks a pending request, optionally issues buffer strobes, then drops ack.
  task automatic serve(input bit release_owner, input int strobes, output int lat);
    exp_t e;
    wait_req(lat);
    pop_check(e);
    bus.host_ack = 1'b1;
    tick();
    check_val("rdwr_drop", {bus.host_rd, bus.host_wr}, 0);
    check_val("drv_ack_owner", bus.drv_ack, 1 << e.drv);
    if (release_owner) begin
      bus.drv_rd[e.drv] = 1'b0;
      bus.drv_wr[e.drv] = 1'b0;
    end
    for (int k = 0; k < 2 * strobes; k++) begin
      bus.host_buff_wr = ~k[0];
      bus.drv_buff_din = $urandom;
      #1;
      check_val("buff_wr_route", bus.drv_buff_wr, bus.host_buff_wr ? (1 << e.drv) : 0);
      check_val("buff_din_mux", bus.host_buff_din, bus.drv_buff_din[e.drv*8 +: 8]);
      tick();
    end
    bus.host_buff_wr = 1'b0;
    tick();
    check_val("drv_ack_hold", bus.drv_ack, 1 << e.drv);
    bus.host_ack = 1'b0;
    tick();
    check_val("done_ack_low", bus.drv_ack, 0);
    check_val("done_busy", bus.busy, 1);
    tick();
    check_val("idle_busy", bus.busy, 0);
  endtask

  initial begin
    int   lat;
    int   cnt;
    exp_t e;

    reset            = 1'b1;
    bus.drv_rd       = '0;
    bus.drv_wr       = '0;
    bus.drv_lba      = '0;
    bus.drv_blk_cnt  = '0;
    bus.drv_buff_din = 32'hA5C3_7E19;
    bus.host_ack     = 1'b0;
    bus.host_buff_wr = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    reset = 1'b0;

    // Single read on drive 2
    req(2, 1'b1, 1'b0, 32'h0000_0123, 6'd5);
    serve(1'b1, 0, lat);
    check_val("rd_latency", lat, 2);

    // Fairness from ptr=0 with drives 0,1,3 holding requests
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req(0, 1'b1, 1'b0, 32'h1000_0000, 6'd1);
    req(1, 1'b1, 1'b0, 32'h1100_0001, 6'd2);
    req(3, 1'b0, 1'b1, 32'h1300_0003, 6'd3);
    sb_push(0, 32'h1000_0000, 6'd1, 1'b1);
    sb_push(1, 32'h1100_0001, 6'd2, 1'b1);
    sb_push(3, 32'h1300_0003, 6'd3, 1'b0);
    for (int i = 0; i < 6; i++) serve(1'b0, 0, lat);
    bus.drv_rd = '0;
    bus.drv_wr = '0;

    // Buffer routing on drive 3
    req(3, 1'b0, 1'b1, 32'hDEAD_BEEF, 6'd63);
    serve(1'b1, 256, lat);

    // rd+wr together, then wr only, on drive 1
    req(1, 1'b1, 1'b1, 32'h0000_0A01, 6'd7);
    serve(1'b1, 0, lat);
    req(1, 1'b0, 1'b1, 32'h0000_0A02, 6'd8);
    serve(1'b1, 0, lat);

    // Reset during XFER: no ack afterwards, ptr back to 0
    req(2, 1'b1, 1'b0, 32'h0000_0ABC, 6'd1);
    wait_req(lat);
    pop_check(e);
    bus.host_ack = 1'b1;
    tick();
    check_val("pre_reset_ack", bus.drv_ack, 4);
    reset      = 1'b1;
    bus.drv_rd = '0;
    tick();
    check_idle_outputs("xfer_reset");
    reset        = 1'b0;
    bus.host_ack = 1'b0;
    tick();
    check_val("post_reset_ack", bus.drv_ack, 0);
    req(3, 1'b1, 1'b0, 32'h0000_3333, 6'd3);
    sb.delete(sb.size() - 1);
    req(1, 1'b1, 1'b0, 32'h0000_1111, 6'd1);
    sb_push(3, 32'h0000_3333, 6'd3, 1'b1);
    serve(1'b1, 0, lat);
    serve(1'b1, 0, lat);

`ifdef SD_ARB_TIMEOUT_EN
    // Watchdog: host never acks drive 0, drive 1 is served next
    req(0, 1'b1, 1'b0, 32'h0000_0F00, 6'd2);
    req(1, 1'b0, 1'b1, 32'h0000_0F01, 6'd4);
    wait_req(lat);
    pop_check(e);
    cnt = 0;
    while (bus.host_rd && cnt < 200) begin
      tick();
      cnt++;
    end
    check_val("tmo_rd_len", cnt, 63);
    check_val("tmo_err", bus.err, 1);
    check_val("tmo_no_ack", bus.drv_ack, 0);
    bus.drv_rd[0] = 1'b0;
    tick();
    check_val("tmo_err_pulse", bus.err, 0);
    serve(1'b1, 0, lat);
`endif

    check_val("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
